// File: rtl/switch_alloc_wh.sv
// -----------------------------------------------------------------------------
// switch_alloc_wh
//
// Wormhole switch allocator with credit-based flow control. Each output port
// has its own two-state FSM (IDLE / LOCKED), an owner register and a
// round-robin pointer. In IDLE an output grants the first requesting head
// flit, searching from its pointer upward. In LOCKED it only serves the input
// that owns the packet in flight. Grants are combinational and appear in the
// same cycle as the request. A per-output credit counter mirrors the free
// slots in the downstream buffer.
//
// Ports
//   clk             : single clock, rising-edge active
//   reset           : asynchronous, active-high reset
//   ce              : clock enable for grants and FSM/owner/pointer updates
//   i_output_req    : [input][output] request matrix, one-hot per input
//   i_head          : per input, head-of-queue flit is a head flit
//   i_tail          : per input, head-of-queue flit is a tail flit
//   i_credit_return : per output, downstream freed one buffer slot
//   o_output_grant  : [output][input] grant matrix, one-hot or zero per output
//   o_input_grant   : per input, OR of all output grant rows
//   o_credit_count  : per output, credits currently available
//   o_locked        : per output, held by an in-flight packet
// -----------------------------------------------------------------------------
module switch_alloc_wh #(
  parameter int N     = 5,
  parameter int M     = 5,
  parameter int DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   ce,
  input  logic [0:N-1][0:M-1]                    i_output_req,
  input  logic [0:N-1]                           i_head,
  input  logic [0:N-1]                           i_tail,
  input  logic [0:M-1]                           i_credit_return,
  output logic [0:M-1][0:N-1]                    o_output_grant,
  output logic [0:N-1]                           o_input_grant,
  output logic [0:M-1][$clog2(DEPTH+1)-1:0]      o_credit_count,
  output logic [0:M-1]                           o_locked
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  for (genvar i = 0; i < M; i++) begin : g_out

    state_t          state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cred_q, cred_d;
    logic [0:N-1]    grant_row;
    logic            granted;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   idx;
    logic [PW-1:0]   ptr_next;

    // Arbitration, next-state and credit update for this output. Grants are
    // suppressed while reset is high so the outputs drop immediately on an
    // asynchronous reset, independent of any clock edge.
    always_comb begin
      grant_row = '0;
      granted   = 1'b0;
      winner    = owner_q;
      idx       = '0;
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      cred_d    = cred_q;

      if (!reset && ce && (cred_q != '0)) begin
        if (state_q == LOCKED) begin
          // Only the owner may continue; a head flit from the owner here is
          // treated as just another body flit.
          if (i_output_req[owner_q][i]) begin
            granted            = 1'b1;
            winner             = owner_q;
            grant_row[owner_q] = 1'b1;
          end
        end else begin
          for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_q) + k) % N);
            if (!granted && i_output_req[idx][i] && i_head[idx]) begin
              granted        = 1'b1;
              winner         = idx;
              grant_row[idx] = 1'b1;
            end
          end
        end
      end

      ptr_next = (winner == PW'(N - 1)) ? '0 : winner + 1'b1;

      // The pointer only moves past the winner when a packet completes.
      if (granted) begin
        if (state_q == IDLE) begin
          if (!i_tail[winner]) begin
            state_d = LOCKED;
            owner_d = winner;
          end else begin
            ptr_d = ptr_next;
          end
        end else if (i_tail[winner]) begin
          state_d = IDLE;
          ptr_d   = ptr_next;
        end
      end

      // Credits keep counting returns even with ce low; a return at DEPTH
      // is dropped so the counter saturates.
      if (granted && !i_credit_return[i]) begin
        cred_d = cred_q - CW'(1);
      end else if (!granted && i_credit_return[i] && (cred_q != CW'(DEPTH))) begin
        cred_d = cred_q + CW'(1);
      end
    end

    // State, owner, pointer and credit registers for this output.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        owner_q <= '0;
        ptr_q   <= '0;
        cred_q  <= CW'(DEPTH);
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
        cred_q  <= cred_d;
      end
    end

    assign o_output_grant[i] = grant_row;
    assign o_credit_count[i] = cred_q;
    assign o_locked[i]       = (state_q == LOCKED);

  end

  // Each input sees whether any output picked it this cycle.
  always_comb begin
    o_input_grant = '0;
    for (int m = 0; m < M; m++) begin
      o_input_grant = o_input_grant | o_output_grant[m];
    end
  end

endmodule

// File: tb/tb_switch_alloc_wh.sv
// -----------------------------------------------------------------------------
// tb_switch_alloc_wh
//
// Directed bench for switch_alloc_wh with N=M=4, DEPTH=2. Each step drives the
// inputs on the falling clock edge, pushes the hand-derived expected outputs
// onto a scoreboard queue, and pops/compares them shortly afterwards, well
// before the next rising edge commits the state.
// -----------------------------------------------------------------------------
module tb_switch_alloc_wh;

  localparam int N     = 4;
  localparam int M     = 4;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     ce;
  logic [0:N-1][0:M-1]      i_output_req;
  logic [0:N-1]             i_head;
  logic [0:N-1]             i_tail;
  logic [0:M-1]             i_credit_return;
  logic [0:M-1][0:N-1]      o_output_grant;
  logic [0:N-1]             o_input_grant;
  logic [0:M-1][CW-1:0]     o_credit_count;
  logic [0:M-1]             o_locked;

  typedef struct {
    string                  tag;
    logic [0:M-1][0:N-1]    grant;
    logic [0:N-1]           in_grant;
    logic [0:M-1]           locked;
    logic [0:M-1][CW-1:0]   cred;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  switch_alloc_wh #(
    .N     (N),
    .M     (M),
    .DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ce              (ce),
    .i_output_req    (i_output_req),
    .i_head          (i_head),
    .i_tail          (i_tail),
    .i_credit_return (i_credit_return),
    .o_output_grant  (o_output_grant),
    .o_input_grant   (o_input_grant),
    .o_credit_count  (o_credit_count),
    .o_locked        (o_locked)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Request matrix with input a_in asking for output a_out.
  function automatic logic [0:N-1][0:M-1] rq(input int a_in, input int a_out);
    logic [0:N-1][0:M-1] r;
    r = '0;
    r[a_in][a_out] = 1'b1;
    return r;
  endfunction

  // Grant matrix with output a_out granted to input a_in.
  function automatic logic [0:M-1][0:N-1] gr(input int a_out, input int a_in);
    logic [0:M-1][0:N-1] g;
    g = '0;
    g[a_out][a_in] = 1'b1;
    return g;
  endfunction

  // Drive one cycle of stimulus and record what the outputs must show.
  task automatic apply_stimulus(
    input string                 tag,
    input logic                  rst_v,
    input logic                  ce_v,
    input logic [0:N-1][0:M-1]   req,
    input logic [0:N-1]          head,
    input logic [0:N-1]          tail,
    input logic [0:M-1]          ret,
    input logic [0:M-1][0:N-1]   eg,
    input logic [0:M-1]          el,
    input logic [0:M-1][CW-1:0]  ec
  );
    exp_t e;
    reset           = rst_v;
    ce              = ce_v;
    i_output_req    = req;
    i_head          = head;
    i_tail          = tail;
    i_credit_return = ret;
    e.tag      = tag;
    e.grant    = eg;
    e.in_grant = '0;
    for (int m = 0; m < M; m++) begin
      e.in_grant = e.in_grant | eg[m];
    end
    e.locked = el;
    e.cred   = ec;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic check_output();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty observed=0 entries expected>=1");
      return;
    end
    e = sb.pop_front();
    assert (o_output_grant === e.grant) else begin
      failures++;
      $error("[TB] FAIL %s output_grant observed=%h expected=%h", e.tag, o_output_grant, e.grant);
    end
    checks++;
    assert (o_input_grant === e.in_grant) else begin
      failures++;
      $error("[TB] FAIL %s input_grant observed=%b expected=%b", e.tag, o_input_grant, e.in_grant);
    end
    checks++;
    assert (o_locked === e.locked) else begin
      failures++;
      $error("[TB] FAIL %s locked observed=%b expected=%b", e.tag, o_locked, e.locked);
    end
    checks++;
    assert (o_credit_count === e.cred) else begin
      failures++;
      $error("[TB] FAIL %s credit_count observed=%h expected=%h", e.tag, o_credit_count, e.cred);
    end
  endtask

  // Bit ordering of the [0:3] vectors: index 0 is the leftmost literal bit.
  // Credit vectors are written {out0, out1, out2, out3}.
  initial begin
    reset           = 1'b1;
    ce              = 1'b1;
    i_output_req    = '0;
    i_head          = '0;
    i_tail          = '0;
    i_credit_return = '0;

    // Reset held: requests are present but nothing may be granted.
    @(negedge clk);
    apply_stimulus("rst_hold", 1'b1, 1'b1, rq(0,3), 4'b1000, 4'b1000, 4'b0000,
                   '0, 4'b0000, {2'd2, 2'd2, 2'd2, 2'd2});
    #2 check_output();

    // Round robin on output 3: single-flit packets from inputs 0,1,2 with a
    // credit return every cycle.
    @(negedge clk);
    apply_stimulus("rr0", 1'b0, 1'b1, rq(0,3) | rq(1,3) | rq(2,3), 4'b1110, 4'b1110, 4'b0001,
                   gr(3,0), 4'b0000, {2'd2, 2'd2, 2'd2, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("rr1", 1'b0, 1'b1, rq(0,3) | rq(1,3) | rq(2,3), 4'b1110, 4'b1110, 4'b0001,
                   gr(3,1), 4'b0000, {2'd2, 2'd2, 2'd2, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("rr2", 1'b0, 1'b1, rq(0,3) | rq(1,3) | rq(2,3), 4'b1110, 4'b1110, 4'b0001,
                   gr(3,2), 4'b0000, {2'd2, 2'd2, 2'd2, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("rr3", 1'b0, 1'b1, rq(0,3) | rq(1,3) | rq(2,3), 4'b1110, 4'b1110, 4'b0001,
                   gr(3,0), 4'b0000, {2'd2, 2'd2, 2'd2, 2'd2});
    #2 check_output();

    // Wormhole lock on output 0: input 1 sends head/body/tail while input 2
    // keeps a single-flit head request pending.
    @(negedge clk);
    apply_stimulus("wh_head", 1'b0, 1'b1, rq(1,0) | rq(2,0), 4'b0110, 4'b0010, 4'b1000,
                   gr(0,1), 4'b0000, {2'd2, 2'd2, 2'd2, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("wh_body", 1'b0, 1'b1, rq(1,0) | rq(2,0), 4'b0010, 4'b0010, 4'b1000,
                   gr(0,1), 4'b1000, {2'd2, 2'd2, 2'd2, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("wh_tail", 1'b0, 1'b1, rq(1,0) | rq(2,0), 4'b0010, 4'b0110, 4'b1000,
                   gr(0,1), 4'b1000, {2'd2, 2'd2, 2'd2, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("wh_next", 1'b0, 1'b1, rq(2,0), 4'b0010, 4'b0010, 4'b1000,
                   gr(0,2), 4'b0000, {2'd2, 2'd2, 2'd2, 2'd2});
    #2 check_output();

    // Credit stall on output 2: three single flits from input 0, no returns.
    @(negedge clk);
    apply_stimulus("cs0", 1'b0, 1'b1, rq(0,2), 4'b1000, 4'b1000, 4'b0000,
                   gr(2,0), 4'b0000, {2'd2, 2'd2, 2'd2, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("cs1", 1'b0, 1'b1, rq(0,2), 4'b1000, 4'b1000, 4'b0000,
                   gr(2,0), 4'b0000, {2'd2, 2'd2, 2'd1, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("cs_stall", 1'b0, 1'b1, rq(0,2), 4'b1000, 4'b1000, 4'b0000,
                   '0, 4'b0000, {2'd2, 2'd2, 2'd0, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("cs_return", 1'b0, 1'b1, rq(0,2), 4'b1000, 4'b1000, 4'b0010,
                   '0, 4'b0000, {2'd2, 2'd2, 2'd0, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("cs_third", 1'b0, 1'b1, rq(0,2), 4'b1000, 4'b1000, 4'b0000,
                   gr(2,0), 4'b0000, {2'd2, 2'd2, 2'd1, 2'd2});
    #2 check_output();

    // Grant and return together at count 1, then saturation at DEPTH.
    @(negedge clk);
    apply_stimulus("cr_ret", 1'b0, 1'b1, '0, 4'b0000, 4'b0000, 4'b0010,
                   '0, 4'b0000, {2'd2, 2'd2, 2'd0, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("cr_both", 1'b0, 1'b1, rq(0,2), 4'b1000, 4'b1000, 4'b0010,
                   gr(2,0), 4'b0000, {2'd2, 2'd2, 2'd1, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("cr_hold1", 1'b0, 1'b1, '0, 4'b0000, 4'b0000, 4'b0010,
                   '0, 4'b0000, {2'd2, 2'd2, 2'd1, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("cr_sat", 1'b0, 1'b1, '0, 4'b0000, 4'b0000, 4'b0010,
                   '0, 4'b0000, {2'd2, 2'd2, 2'd2, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("cr_full", 1'b0, 1'b1, '0, 4'b0000, 4'b0000, 4'b0000,
                   '0, 4'b0000, {2'd2, 2'd2, 2'd2, 2'd2});
    #2 check_output();

    // Clock enable low mid-packet on output 1 with credit returns.
    @(negedge clk);
    apply_stimulus("ce_head", 1'b0, 1'b1, rq(3,1), 4'b0001, 4'b0000, 4'b0000,
                   gr(1,3), 4'b0000, {2'd2, 2'd2, 2'd2, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("ce_body", 1'b0, 1'b1, rq(3,1), 4'b0000, 4'b0000, 4'b0000,
                   gr(1,3), 4'b0100, {2'd2, 2'd1, 2'd2, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("ce_off0", 1'b0, 1'b0, rq(3,1) | rq(0,1), 4'b1000, 4'b0000, 4'b0100,
                   '0, 4'b0100, {2'd2, 2'd0, 2'd2, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("ce_off1", 1'b0, 1'b0, rq(3,1) | rq(0,1), 4'b1000, 4'b0000, 4'b0100,
                   '0, 4'b0100, {2'd2, 2'd1, 2'd2, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("ce_off2", 1'b0, 1'b0, rq(3,1) | rq(0,1), 4'b1000, 4'b0000, 4'b0000,
                   '0, 4'b0100, {2'd2, 2'd2, 2'd2, 2'd2});
    #2 check_output();
    // Owner presents a head flit while locked: served as a body flit.
    @(negedge clk);
    apply_stimulus("ce_on_head", 1'b0, 1'b1, rq(3,1) | rq(0,1), 4'b1001, 4'b0000, 4'b0000,
                   gr(1,3), 4'b0100, {2'd2, 2'd2, 2'd2, 2'd2});
    #2 check_output();

    // Asynchronous reset in the middle of the packet, between clock edges.
    @(negedge clk);
    apply_stimulus("rst_pre", 1'b0, 1'b1, rq(3,1), 4'b0000, 4'b0000, 4'b0000,
                   gr(1,3), 4'b0100, {2'd2, 2'd1, 2'd2, 2'd2});
    #2 check_output();
    #1;
    apply_stimulus("rst_async", 1'b1, 1'b1, rq(3,1), 4'b0000, 4'b0000, 4'b0000,
                   '0, 4'b0000, {2'd2, 2'd2, 2'd2, 2'd2});
    #1 check_output();
    @(negedge clk);
    apply_stimulus("rst_hold2", 1'b1, 1'b1, rq(3,1), 4'b0000, 4'b0000, 4'b0000,
                   '0, 4'b0000, {2'd2, 2'd2, 2'd2, 2'd2});
    #2 check_output();

    // After release: lock abandoned and pointers back at 0.
    @(negedge clk);
    apply_stimulus("post_rst", 1'b0, 1'b1, rq(0,3) | rq(1,3) | rq(2,1) | rq(3,1),
                   4'b1111, 4'b1110, 4'b0000,
                   gr(3,0) | gr(1,2), 4'b0000, {2'd2, 2'd2, 2'd2, 2'd2});
    #2 check_output();
    @(negedge clk);
    apply_stimulus("post_idle", 1'b0, 1'b1, '0, 4'b0000, 4'b0000, 4'b0000,
                   '0, 4'b0000, {2'd2, 2'd1, 2'd2, 2'd1});
    #2 check_output();

    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
